seq_arith_unit: RTL and testbench
=================================

# seq_arith_unit

Parametrised, multi-cycle arithmetic unit for the FSM CPU datapath. It is the successor to the single-cycle combinational arithmetic unit and adds the following:
- generic operand width;
- valid/ready handshakes on input and output;
- iterative shift-add multiply and restoring divide, trading latency for area;
- remainder output and status flags.

The CPU control FSM issues one operation at a time and stalls on `in_ready`/`out_valid`.

## Interface
- `WIDTH`, default 16: operand width in bits. Must be ≥ 2; the result is `2*WIDTH` bits.
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operation request.
- `in_ready` output 1: unit can accept a request.
- `a`, `b` input `WIDTH` each: unsigned operands.
- `opcode` input 3: 000 add, 001 sub, 010 mul, 011 div, others illegal.
- `result` output `2*WIDTH`: registered result.
- `status` output 4: registered flags. {3 illegal, 2 div_zero, 1 zero, 0 carry}.
- `out_valid` output 1: `result`/`status` valid.
- `out_ready` input 1: consumer takes the result.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - MUL: iterating.
  - DIV: iterating.
  - DONE: `out_valid`=1.
- Accept happens on the edge where `in_valid && in_ready`. `a`, `b` and `opcode` are captured that edge; the inputs are don't-care afterwards.
- Transitions out of IDLE on accept:
  - add, sub, illegal, or div with `b`==0: go directly to DONE with the result computed.
  - mul: go to MUL.
  - div with `b`≠0: go to DIV.
  - The iteration counter is loaded with `WIDTH`.
- MUL/DIV:
  - One iteration per cycle, counter decrements.
  - When the counter reaches 0, the final value is written to `result` and the FSM goes to DONE on the same edge.
- DONE:
  - On `out_ready`=1, go to IDLE.
  - Otherwise hold. `result` and `status` stay stable.
- Arithmetic (unsigned):
  - add: `result` = zero-extended low `WIDTH` bits of `a+b`; carry = carry-out.
  - sub: `result` = zero-extended low `WIDTH` bits of `a-b`; carry = borrow (`a<b`).
  - mul: `result` = full `2*WIDTH`-bit product, LSB-first shift-add; carry=0.
  - div:
    - `result` = {remainder[`WIDTH`-1:0], quotient[`WIDTH`-1:0]}, restoring algorithm MSB-first; carry=0.
    - If `b`==0: `result` = all ones, div_zero=1, no iteration.
  - illegal opcode: `result`=0, illegal=1.
  - zero = (`result`==0), evaluated on the final `result`. This applies to every op, including illegal.
- No overlap: a new request is never accepted while an operation is in flight or a result is unconsumed.

## Timing
- Reset (asserted, asynchronously):
  - FSM goes to IDLE; counter=0.
  - `result`=0, `status`=0, `out_valid`=0, `in_ready`=1 (`in_ready` rises once reset is applied).
- Reset asserted mid-iteration or in DONE: the operation is abandoned with no output.
- Latency from the accept edge to `out_valid`=1:
  - 1 cycle for add, sub, illegal, div-by-zero.
  - `WIDTH`+1 cycles for mul and for div with `b`≠0 (17 for `WIDTH`=16).
- Output handshake:
  - `out_valid` falls on the edge after `out_valid && out_ready`.
  - `in_ready` rises on that same edge.
  - Minimum issue interval: 2 cycles for single-cycle ops, `WIDTH`+2 for mul/div.
- `in_valid` while busy is ignored and does not queue.
- `out_ready` held high before DONE: the result is still presented for exactly one cycle.
- `in_ready` and `out_valid` are mutually exclusive and both registered/state-decoded. There is no combinational path from input to output.

## Test plan
- Add, `WIDTH`=16: `a`=0xFFFF, `b`=0x0001 → 1 cycle later `result`=0x00000000, `status`=0b0011 (zero, carry). Sub `a`=3, `b`=5 → `result`=0x0000FFFE, `status`=0b0001.
- Mul: 0xFFFF × 0xFFFF → `out_valid` exactly 17 cycles after accept, `result`=0xFFFE0001, `status`=0. Also 0x1234 × 0 → `result`=0, zero=1.
- Div: 1000 ÷ 7 → after 17 cycles `result`=0x0006008E (rem 6, quot 142). Also 5 ÷ 9 → `result`=0x00050000. Div 0x00AB ÷ 0 → 1 cycle, `result`=0xFFFFFFFF, `status`=0b0100.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `result`/`status` stable, `in_ready`=0, a pulsing `in_valid` is ignored. Then `out_ready`=1 → next cycle `out_valid`=0, `in_ready`=1.
- Reset mid-mul: assert `rst_n`=0 at iteration 8 → all outputs reach reset values asynchronously. After release, a new add completes normally in 1 cycle.
- Opcode 0b101 → `result`=0, `status`=0b1010 (illegal, zero). Also run `WIDTH`=8 and `WIDTH`=32 with random ops against a reference model, checking results and latency (`WIDTH`+1 for mul/div).

Source files
------------

// File: rtl/seq_arith_unit_if.sv
// seq_arith_unit_if: request/response bundle between the CPU control FSM and seq_arith_unit.
interface seq_arith_unit_if #(parameter int WIDTH = 16);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2:0]           opcode;
    logic [2*WIDTH-1:0]   result;
    logic [3:0]           status;
    logic                 out_valid;
    logic                 out_ready;
    modport master (output in_valid, a, b, opcode, out_ready,
                    input  in_ready, result, status, out_valid);
    modport slave  (input  in_valid, a, b, opcode, out_ready,
                    output in_ready, result, status, out_valid);
endinterface

// File: rtl/seq_arith_unit.sv
// seq_arith_unit: multi-cycle unsigned add/sub/mul/div with valid/ready handshakes.
// mul is LSB-first shift-add, div is MSB-first restoring; both share the hi/lo registers.
module seq_arith_unit #(parameter int WIDTH = 16) (
    input logic            clk,
    input logic            rst_n,
    seq_arith_unit_if.slave io_bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    state_t               r_state, w_next;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_hi, r_lo, r_b;
    logic [2*WIDTH-1:0]   r_result;
    logic [3:0]           r_status;
    logic [WIDTH:0]       w_sum, w_sh, w_trial, w_add, w_sub;
    logic [WIDTH-1:0]     w_hi_n, w_lo_n;
    logic [2*WIDTH-1:0]   w_q_res;
    logic                 w_accept, w_last, w_bz, w_ill, w_q_carry;

    assign w_accept = (r_state == S_IDLE) && io_bus.in_valid;
    assign w_last   = r_cnt == CW'(1);
    assign w_bz     = io_bus.b == '0;
    assign w_ill    = io_bus.opcode[2];

    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_sh    = {r_hi, r_lo[WIDTH-1]};
        w_trial = w_sh - {1'b0, r_b};
        // bit WIDTH of the trial difference is the restoring-divide borrow
        w_hi_n  = (r_state == S_MUL) ? w_sum[WIDTH:1]
                : (w_trial[WIDTH] ? w_sh[WIDTH-1:0] : w_trial[WIDTH-1:0]);
        w_lo_n  = (r_state == S_MUL) ? {w_sum[0], r_lo[WIDTH-1:1]}
                : {r_lo[WIDTH-2:0], ~w_trial[WIDTH]};
        w_add   = {1'b0, io_bus.a} + {1'b0, io_bus.b};
        w_sub   = {1'b0, io_bus.a} - {1'b0, io_bus.b};
        // only add, sub, div-by-zero and illegal take the single-cycle path
        w_q_res   = w_ill ? '0 : io_bus.opcode[1] ? '1
                  : {{WIDTH{1'b0}}, io_bus.opcode[0] ? w_sub[WIDTH-1:0] : w_add[WIDTH-1:0]};
        w_q_carry = !w_ill && !io_bus.opcode[1] && (io_bus.opcode[0] ? w_sub[WIDTH] : w_add[WIDTH]);
        w_next  = r_state;
        case (r_state)
            S_IDLE:  w_next = !io_bus.in_valid ? S_IDLE
                            : (io_bus.opcode == 3'd2) ? S_MUL
                            : (io_bus.opcode == 3'd3 && !w_bz) ? S_DIV : S_DONE;
            S_DONE:  w_next = io_bus.out_ready ? S_IDLE : S_DONE;
            default: w_next = w_last ? S_DONE : r_state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_status <= '0;
        end else if (w_accept) begin
            r_cnt <= CW'(WIDTH);
            r_hi  <= '0;
            r_lo  <= io_bus.a;
            r_b   <= io_bus.b;
            if (w_next == S_DONE) begin
                r_result <= w_q_res;
                r_status <= {w_ill, !w_ill && io_bus.opcode[1], w_q_res == '0, w_q_carry};
            end
        end else if (r_state == S_MUL || r_state == S_DIV) begin
            r_cnt <= r_cnt - CW'(1);
            r_hi  <= w_hi_n;
            r_lo  <= w_lo_n;
            if (w_last) begin
                r_result <= {w_hi_n, w_lo_n};
                r_status <= {2'b00, {w_hi_n, w_lo_n} == '0, 1'b0};
            end
        end
    end

    assign io_bus.in_ready  = r_state == S_IDLE;
    assign io_bus.out_valid = r_state == S_DONE;
    assign io_bus.result    = r_result;
    assign io_bus.status    = r_status;
endmodule

// File: tb/tb_seq_arith_unit.sv
// tb_seq_arith_unit: directed and randomized checks of seq_arith_unit at WIDTH 8, 16 and 32.
module tb_seq_arith_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    seq_arith_unit_if #(.WIDTH(8))  i8 ();
    seq_arith_unit_if #(.WIDTH(16)) i16 ();
    seq_arith_unit_if #(.WIDTH(32)) i32 ();

    seq_arith_unit #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .io_bus(i8));
    seq_arith_unit #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .io_bus(i16));
    seq_arith_unit #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .io_bus(i32));

    function automatic logic [63:0] g_res(int w);
        return (w == 8) ? 64'(i8.result) : (w == 16) ? 64'(i16.result) : 64'(i32.result);
    endfunction
    function automatic logic [3:0] g_st(int w);
        return (w == 8) ? i8.status : (w == 16) ? i16.status : i32.status;
    endfunction
    function automatic logic g_ov(int w);
        return (w == 8) ? i8.out_valid : (w == 16) ? i16.out_valid : i32.out_valid;
    endfunction
    function automatic logic g_ir(int w);
        return (w == 8) ? i8.in_ready : (w == 16) ? i16.in_ready : i32.in_ready;
    endfunction

    // reference: {status, result} straight from the arithmetic definitions
    function automatic logic [67:0] model(int w, logic [31:0] a, logic [31:0] b, logic [2:0] op);
        longint unsigned ua, ub, m, r;
        logic c, dz, il;
        ua = 64'(a); ub = 64'(b); m = (64'd1 << w) - 1;
        c = 1'b0; dz = 1'b0; il = 1'b0; r = 0;
        case (op)
            3'd0: begin r = (ua + ub) & m; c = ((ua + ub) >> w) != 0; end
            3'd1: begin r = (ua - ub) & m; c = ua < ub; end
            3'd2: r = ua * ub;
            3'd3: if (ub == 0) begin r = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << (2 * w)) - 1; dz = 1'b1; end
                  else r = ((ua % ub) << w) | (ua / ub);
            default: il = 1'b1;
        endcase
        return {il, dz, r == 0, c, r};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int w, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        i8.in_valid  = v && w == 8;  i8.a  = a[7:0];  i8.b  = b[7:0];  i8.opcode  = op;
        i16.in_valid = v && w == 16; i16.a = a[15:0]; i16.b = b[15:0]; i16.opcode = op;
        i32.in_valid = v && w == 32; i32.a = a;       i32.b = b;       i32.opcode = op;
    endtask

    task automatic set_oready(input logic v);
        i8.out_ready = v; i16.out_ready = v; i32.out_ready = v;
    endtask

    task automatic issue(input int w, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input string tag);
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(g_ir(w)), 64'd1);
        drive(w, 1'b1, a, b, op);
        @(negedge clk);
        drive(w, 1'b0, $urandom, $urandom, 3'($urandom));
    endtask

    task automatic await_done(input int w, input int el, input string tag);
        int lat = 1;
        while (!g_ov(w) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(el));
    endtask

    task automatic retire(input int w, input logic [63:0] er, input logic [3:0] es, input string tag);
        chk({tag, "_result"}, g_res(w), er);
        chk({tag, "_status"}, 64'(g_st(w)), 64'(es));
        chk({tag, "_busy"}, 64'(g_ir(w)), 64'd0);
        set_oready(1'b1);
        @(negedge clk);
        chk({tag, "_ov_fall"}, 64'(g_ov(w)), 64'd0);
        chk({tag, "_ir_rise"}, 64'(g_ir(w)), 64'd1);
        set_oready(1'b0);
    endtask

    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic [63:0] er, input logic [3:0] es, input int el, input string tag);
        issue(w, a, b, op, tag);
        await_done(w, el, tag);
        retire(w, er, es, tag);
    endtask

    initial begin
        int ws[3] = '{8, 16, 32};
        logic [63:0] r0, m;
        logic [3:0]  s0;
        logic [67:0] ex;
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        drive(16, 1'b0, 0, 0, 0);
        set_oready(1'b0);
        repeat (2) @(negedge clk);
        foreach (ws[k]) begin
            chk($sformatf("rst%0d_in_ready", ws[k]), 64'(g_ir(ws[k])), 64'd1);
            chk($sformatf("rst%0d_out_valid", ws[k]), 64'(g_ov(ws[k])), 64'd0);
            chk($sformatf("rst%0d_result", ws[k]), g_res(ws[k]), 64'd0);
            chk($sformatf("rst%0d_status", ws[k]), 64'(g_st(ws[k])), 64'd0);
        end
        rst_n = 1'b1;

        run_op(16, 32'hFFFF, 32'h1, 3'd0, 64'h0, 4'b0011, 1, "add_ovf");
        run_op(16, 32'd3, 32'd5, 3'd1, 64'h0000FFFE, 4'b0001, 1, "sub_borrow");
        run_op(16, 32'hFFFF, 32'hFFFF, 3'd2, 64'hFFFE0001, 4'b0000, 17, "mul_max");
        run_op(16, 32'h1234, 32'h0, 3'd2, 64'h0, 4'b0010, 17, "mul_zero");
        run_op(16, 32'd1000, 32'd7, 3'd3, 64'h0006008E, 4'b0000, 17, "div_1000_7");
        run_op(16, 32'd5, 32'd9, 3'd3, 64'h00050000, 4'b0000, 17, "div_5_9");
        run_op(16, 32'h00AB, 32'h0, 3'd3, 64'hFFFFFFFF, 4'b0100, 1, "div_zero");
        run_op(16, 32'h55, 32'h66, 3'd5, 64'h0, 4'b1010, 1, "illegal");

        // backpressure in DONE with in_valid pulsing
        issue(16, 32'd200, 32'd3, 3'd2, "bp");
        await_done(16, 17, "bp");
        chk("bp_result", g_res(16), 64'd600);
        r0 = g_res(16);
        s0 = g_st(16);
        for (int i = 0; i < 5; i++) begin
            drive(16, (i % 2) == 0, 32'd9, 32'd9, 3'd0);
            @(negedge clk);
            chk($sformatf("bp_hold%0d_result", i), g_res(16), r0);
            chk($sformatf("bp_hold%0d_status", i), 64'(g_st(16)), 64'(s0));
            chk($sformatf("bp_hold%0d_in_ready", i), 64'(g_ir(16)), 64'd0);
            chk($sformatf("bp_hold%0d_out_valid", i), 64'(g_ov(16)), 64'd1);
        end
        drive(16, 1'b0, 0, 0, 0);
        set_oready(1'b1);
        @(negedge clk);
        chk("bp_release_ov", 64'(g_ov(16)), 64'd0);
        chk("bp_release_ir", 64'(g_ir(16)), 64'd1);
        set_oready(1'b0);
        repeat (3) @(negedge clk);
        chk("bp_no_queue_ov", 64'(g_ov(16)), 64'd0);
        chk("bp_no_queue_ir", 64'(g_ir(16)), 64'd1);

        // out_ready already high: result shown for exactly one cycle
        set_oready(1'b1);
        issue(16, 32'd7, 32'd8, 3'd0, "early_rdy");
        chk("early_rdy_ov", 64'(g_ov(16)), 64'd1);
        chk("early_rdy_result", g_res(16), 64'd15);
        @(negedge clk);
        chk("early_rdy_ov_fall", 64'(g_ov(16)), 64'd0);
        chk("early_rdy_ir", 64'(g_ir(16)), 64'd1);
        set_oready(1'b0);

        // asynchronous reset in the middle of a multiply
        issue(16, 32'hFFFF, 32'hFFFF, 3'd2, "rst_mul");
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mul_in_ready", 64'(g_ir(16)), 64'd1);
        chk("rst_mul_out_valid", 64'(g_ov(16)), 64'd0);
        chk("rst_mul_result", g_res(16), 64'd0);
        chk("rst_mul_status", 64'(g_st(16)), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16, 32'h10, 32'h20, 3'd0, 64'h30, 4'b0000, 1, "add_after_rst");

        foreach (ws[k]) begin
            m = (ws[k] == 32) ? 64'hFFFF_FFFF : (64'd1 << ws[k]) - 1;
            for (int n = 0; n < 30; n++) begin
                ra  = 32'($urandom & m);
                rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom & m);
                rop = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
                ex  = model(ws[k], ra, rb, rop);
                run_op(ws[k], ra, rb, rop, ex[63:0], ex[67:64],
                       (rop == 3'd2 || (rop == 3'd3 && rb != 0)) ? ws[k] + 1 : 1,
                       $sformatf("rnd%0d_%0d_op%0d", ws[k], n, rop));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
